// File: rtl/cache_arb_itf.sv
// Shared types and defaults for the cache/memory arbiter.
// Used by cache_mem_arbiter and arb_pick.
package cache_arb_itf;

  localparam int ARB_ADDR_W = 32;
  localparam int ARB_LINE_W = 256;

  typedef enum logic [1:0] {
    IDLE,
    GNT_I,
    GNT_D,
    DONE
  } arb_state_t;

  typedef enum logic {
    SRC_I,
    SRC_D
  } arb_src_t;

  // Returns the requester that did not just finish; the round-robin pointer uses it.
  function automatic arb_src_t other_src(input arb_src_t s);
    return (s == SRC_I) ? SRC_D : SRC_I;
  endfunction

endpackage

// File: rtl/cache_mem_arbiter_pick.sv
// Two-way request picker.
// When both caches request, the prio input decides the winner.
// With no request the output is SRC_D; the caller ignores it because nothing is requesting.
module arb_pick
  import cache_arb_itf::*;
(
  input  logic     req_i,
  input  logic     req_d,
  input  arb_src_t prio,
  output arb_src_t winner
);

  // pick the sole requester, or the prioritised one on a tie
  always_comb begin
    winner = SRC_D;
    if (req_i && req_d) begin
      winner = prio;
    end else if (req_i) begin
      winner = SRC_I;
    end
  end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Arbiter that shares one cacheline-adaptor port between the I-cache and the D-cache.
// A grant is latched for each burst, and the response is routed only to the granted cache.
// Optional macro ARB_ROUND_ROBIN_EN: on a tie, a 1-bit pointer alternates the winner.
// Without the macro, the D-cache always wins a tie.
//
//   state | meaning
//   IDLE  | no strobes; registers the grant decision for the next cycle
//   GNT_I | I-cache burst in flight (read only)
//   GNT_D | D-cache burst in flight (read or writeback)
//   DONE  | one quiet cycle so the requester can drop a serviced request
module cache_mem_arbiter
  import cache_arb_itf::*;
#(
  parameter int ADDR_W = ARB_ADDR_W,
  parameter int LINE_W = ARB_LINE_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_address,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_resp,
  output logic              arb_err
);

  arb_state_t state;
  arb_src_t   prio;
  arb_src_t   winner;
  logic       mem_read_q;
  logic       mem_write_q;
  logic       arb_err_q;
  logic       req_i;
  logic       req_d;
  logic       d_both;

  assign req_i  = i_read;
  assign req_d  = d_read | d_write;
  assign d_both = d_read & d_write;

  arb_pick u_pick (
    .req_i  (req_i),
    .req_d  (req_d),
    .prio   (prio),
    .winner (winner)
  );

`ifdef ARB_ROUND_ROBIN_EN
  // after each completed burst, hand the tie-break to the other cache
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio <= SRC_D;
    end else if (mem_resp && (state == GNT_I)) begin
      prio <= other_src(SRC_I);
    end else if (mem_resp && (state == GNT_D)) begin
      prio <= other_src(SRC_D);
    end
  end
`else
  assign prio = SRC_D;
`endif

  // grant FSM; the strobes are latched at grant and held until mem_resp,
  // because the memory cannot abort or change direction mid-burst
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      arb_err_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (mem_resp) begin
            arb_err_q <= 1'b1;
          end
          if (req_i || req_d) begin
            if (winner == SRC_D) begin
              state       <= GNT_D;
              mem_read_q  <= d_read & ~d_write;
              mem_write_q <= d_write;
              if (d_both) begin
                arb_err_q <= 1'b1;
              end
            end else begin
              state       <= GNT_I;
              mem_read_q  <= 1'b1;
              mem_write_q <= 1'b0;
            end
          end
        end
        GNT_I: begin
          if (mem_resp) begin
            state       <= DONE;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
          end
        end
        GNT_D: begin
          if (d_both) begin
            arb_err_q <= 1'b1;
          end
          if (mem_resp) begin
            state       <= DONE;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
          end
        end
        DONE: begin
          if (mem_resp) begin
            arb_err_q <= 1'b1;
          end
          state <= IDLE;
        end
        default: begin
          state       <= IDLE;
          mem_read_q  <= 1'b0;
          mem_write_q <= 1'b0;
        end
      endcase
    end
  end

  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;
  assign arb_err   = arb_err_q;

  // drive the granted cache's address and data onto the memory port; drive zero when idle
  always_comb begin
    mem_address = '0;
    mem_wdata   = '0;
    case (state)
      GNT_I: mem_address = i_address;
      GNT_D: begin
        mem_address = d_address;
        mem_wdata   = d_wdata;
      end
      default: begin
        mem_address = '0;
        mem_wdata   = '0;
      end
    endcase
  end

  // route the response to the granted cache only while it still requests
  always_comb begin
    i_resp  = (state == GNT_I) && mem_resp && req_i;
    d_resp  = (state == GNT_D) && mem_resp && req_d;
    i_rdata = i_resp ? mem_rdata : '0;
    d_rdata = d_resp ? mem_rdata : '0;
  end

endmodule
